// File: rtl/emulador_de_teclado.sv
// Keypad emulator: presses one key of a 4x4 matrix keypad by returning the target column
// whenever the scanner drives the target line, with contact bounce on press and release.
module emulador_de_teclado #(
    parameter int unsigned HOLD_CYCLES    = 200,
    parameter int unsigned BOUNCE_CYCLES  = 16,
    parameter int unsigned BOUNCE_PERIOD  = 2,
    parameter int unsigned RELEASE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lin_matriz,
    input  logic [3:0] key_value,
    input  logic       key_start,
    output logic       key_ready,
    output logic [3:0] col_matriz,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StBounceIn,
        StHold,
        StBounceOut,
        StRelease,
        StDone
    } state_e;

    localparam logic [15:0] HoldLast    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] BounceLast  = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] ReleaseLast = 16'(RELEASE_CYCLES - 1);
    localparam logic [7:0]  ToggleLast  = 8'(BOUNCE_PERIOD - 1);
    localparam logic        NoBounce    = (BOUNCE_CYCLES == 0);

    state_e      state_q, state_d;
    logic [15:0] dur_q, dur_d;
    logic [7:0]  tog_q, tog_d;
    logic        contact_q, contact_d;
    logic [3:0]  line_q, line_d;
    logic [3:0]  col_q, col_d;

    // Returns {line, column}, both active-low one-hot.
    function automatic logic [7:0] key_map(input logic [3:0] k);
        logic [7:0] m;
        unique case (k)
            4'h1:    m = 8'b0111_0111;
            4'h2:    m = 8'b0111_1011;
            4'h3:    m = 8'b0111_1101;
            4'hA:    m = 8'b0111_1110;
            4'h4:    m = 8'b1011_0111;
            4'h5:    m = 8'b1011_1011;
            4'h6:    m = 8'b1011_1101;
            4'hB:    m = 8'b1011_1110;
            4'h7:    m = 8'b1101_0111;
            4'h8:    m = 8'b1101_1011;
            4'h9:    m = 8'b1101_1101;
            4'hC:    m = 8'b1101_1110;
            4'hF:    m = 8'b1110_0111;
            4'h0:    m = 8'b1110_1011;
            4'hE:    m = 8'b1110_1101;
            default: m = 8'b1110_1110;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            dur_q     <= 16'd0;
            tog_q     <= 8'd0;
            contact_q <= 1'b0;
            line_q    <= 4'hF;
            col_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            tog_q     <= tog_d;
            contact_q <= contact_d;
            line_q    <= line_d;
            col_q     <= col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q + 16'd1;
        tog_d     = tog_q;
        contact_d = contact_q;
        line_d    = line_q;
        col_d     = col_q;
        key_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        // Contact chatter shared by both bounce windows.
        if (state_q == StBounceIn || state_q == StBounceOut) begin
            if (tog_q == ToggleLast) begin
                tog_d     = 8'd0;
                contact_d = ~contact_q;
            end else begin
                tog_d = tog_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                done      = (state_q == StDone);
                dur_d     = 16'd0;
                tog_d     = 8'd0;
                contact_d = 1'b0;
                state_d   = StIdle;
                if (key_start) begin
                    {line_d, col_d} = key_map(key_value);
                    contact_d       = 1'b1;
                    state_d         = NoBounce ? StHold : StBounceIn;
                end
            end
            StBounceIn: begin
                if (dur_q == BounceLast) begin
                    state_d   = StHold;
                    dur_d     = 16'd0;
                    tog_d     = 8'd0;
                    contact_d = 1'b1;
                end
            end
            StHold: begin
                if (dur_q == HoldLast) begin
                    dur_d     = 16'd0;
                    tog_d     = 8'd0;
                    contact_d = !NoBounce;
                    state_d   = NoBounce ? StRelease : StBounceOut;
                end
            end
            StBounceOut: begin
                if (dur_q == BounceLast) begin
                    state_d   = StRelease;
                    dur_d     = 16'd0;
                    tog_d     = 8'd0;
                    contact_d = 1'b0;
                end
            end
            StRelease: begin
                if (dur_q == ReleaseLast) begin
                    state_d = StDone;
                    dur_d   = 16'd0;
                end
            end
            default: begin
                state_d   = StIdle;
                dur_d     = 16'd0;
                tog_d     = 8'd0;
                contact_d = 1'b0;
            end
        endcase
    end

    // Only an exact match of the driven line closes the contact onto the column.
    assign col_matriz = (contact_q && (lin_matriz == line_q)) ? col_q : 4'hF;

endmodule
